// File: rtl/com_bus_arbiter_pkg.sv
// Shared definitions for the common snoop bus arbiter: parameter defaults,
// FSM encoding and the round-robin pointer advance helper.
package com_bus_arbiter_pkg;

  localparam int NUM_REQ_DEF  = 8;
  localparam int MAX_HOLD_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_TURN  = 2'b10
  } arb_state_e;

  // Pointer position just past the winner, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/com_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr,
// wrapping modulo N. Returns one-hot winner, its index and a found flag.
module rr_priority_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_pos    = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = IW'((int'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_pos]) begin
        o_valid         = 1'b1;
        o_onehot[w_pos] = 1'b1;
        o_idx           = w_pos;
      end
    end
  end

endmodule

// File: rtl/com_bus_arbiter.sv
// Round-robin owner of the common snoop bus: one grant at a time, held for the
// owner's whole transaction, a turnaround cycle between owners, watchdog revoke.
module com_bus_arbiter
  import com_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         Com_Bus_Req,
  output logic [NUM_REQ-1:0]         Com_Bus_Gnt,
  output logic [$clog2(NUM_REQ)-1:0] Gnt_id,
  output logic                       Bus_busy,
  output logic                       Timeout_err,
  output logic [1:0]                 o_dbg_state
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  arb_state_e   r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]      r_gnt_id, w_gnt_id_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_tout, w_tout_nxt;
  logic [IW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [HW-1:0]      r_hold_cnt, w_hold_nxt;

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_valid;
  logic               w_owner_req;
  logic               w_wd_fire;

  rr_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req    (Com_Bus_Req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_gnt),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_owner_req = Com_Bus_Req[r_gnt_id];
  // hold_cnt counts completed grant cycles, so MAX_HOLD-1 marks the last one.
  assign w_wd_fire   = (MAX_HOLD != 0) && (r_hold_cnt == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_busy     <= 1'b0;
      r_tout     <= 1'b0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_busy     <= w_busy_nxt;
      r_tout     <= w_tout_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_busy_nxt   = r_busy;
    w_tout_nxt   = 1'b0;
    w_rr_ptr_nxt = r_rr_ptr;
    w_hold_nxt   = r_hold_cnt;
    case (r_state)
      // TURN arbitrates like IDLE; its own cycle already provides the gap.
      ST_IDLE, ST_TURN: begin
        if (w_pick_valid) begin
          w_state_nxt  = ST_GRANT;
          w_gnt_nxt    = w_pick_gnt;
          w_gnt_id_nxt = w_pick_idx;
          w_busy_nxt   = 1'b1;
          w_rr_ptr_nxt = IW'(rr_next(int'(w_pick_idx), NUM_REQ));
          w_hold_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!w_owner_req || w_wd_fire) begin
          w_state_nxt = ST_TURN;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_tout_nxt  = w_owner_req;
        end else if (r_hold_cnt != '1) begin
          w_hold_nxt = r_hold_cnt + HW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign Com_Bus_Gnt = r_gnt;
  assign Gnt_id      = r_gnt_id;
  assign Bus_busy    = r_busy;
  assign Timeout_err = r_tout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Bench for com_bus_arbiter: a default-sized instance for arbitration and a
// MAX_HOLD=4 instance for the watchdog, driven from a per-cycle vector table.
module tb_com_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_m, req_w;
  logic [7:0] gnt_m, gnt_w;
  logic [2:0] id_m, id_w;
  logic       busy_m, busy_w, tout_m, tout_w;
  logic [1:0] st_m, st_w;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       sel;   // 0: main instance, 1: watchdog instance
    logic [7:0] req;
    logic [7:0] gnt;
    logic       tout;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] exp_q[$];
  string      name_q[$];

  com_bus_arbiter #(.NUM_REQ(8), .MAX_HOLD(64)) dut (
    .clk(clk), .rst_n(rst_n), .Com_Bus_Req(req_m), .Com_Bus_Gnt(gnt_m),
    .Gnt_id(id_m), .Bus_busy(busy_m), .Timeout_err(tout_m), .o_dbg_state(st_m)
  );

  com_bus_arbiter #(.NUM_REQ(8), .MAX_HOLD(4)) dut_wd (
    .clk(clk), .rst_n(rst_n), .Com_Bus_Req(req_w), .Com_Bus_Gnt(gnt_w),
    .Gnt_id(id_w), .Bus_busy(busy_w), .Timeout_err(tout_w), .o_dbg_state(st_w)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1, "global timeout");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] idx_of(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) if (oh[b]) r = 3'(b);
    return r;
  endfunction

  task automatic check_out(input logic sel, input string name, input logic [7:0] egnt,
                           input logic etout);
    logic [7:0] agnt;
    logic [2:0] aid;
    logic       abusy, atout;
    agnt  = sel ? gnt_w  : gnt_m;
    aid   = sel ? id_w   : id_m;
    abusy = sel ? busy_w : busy_m;
    atout = sel ? tout_w : tout_m;
    cmp({name, ".gnt"},  32'(agnt),  32'(egnt));
    cmp({name, ".busy"}, 32'(abusy), 32'(|egnt));
    cmp({name, ".tout"}, 32'(atout), 32'(etout));
    if (egnt != 8'h00) cmp({name, ".id"}, 32'(aid), 32'(idx_of(egnt)));
  endtask

  task automatic add(input logic sel, input logic [7:0] req, input logic [7:0] gnt,
                     input logic tout, input string name);
    vec_t v;
    v.sel = sel; v.req = req; v.gnt = gnt; v.tout = tout; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [9:0] e;
    string      nm;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req_m   = '0;
    req_w   = '0;

    // Vector table: req driven before an edge, expected outputs after it.
    for (int i = 0; i < 3; i++) add(0, 8'h00, 8'h00, 0, "idle");
    for (int k = 0; k < 8; k++) begin
      add(0, 8'hFF, 8'(1 << k), 0, $sformatf("rr_grant%0d", k));
      add(0, 8'hFF, 8'(1 << k), 0, $sformatf("rr_hold%0d", k));
      add(0, 8'hFF & ~8'(1 << k), 8'h00, 0, $sformatf("rr_turn%0d", k));
    end
    add(0, 8'hFF, 8'h01, 0, "rr_wrap0");
    add(0, 8'hFE, 8'h00, 0, "rr_wrap_turn");
    for (int i = 0; i < 5; i++) add(0, 8'h04, 8'h04, 0, "single_gnt");
    add(0, 8'h00, 8'h00, 0, "single_turn");
    add(0, 8'h00, 8'h00, 0, "single_idle");
    add(0, 8'h80, 8'h80, 0, "wrap_g7");
    add(0, 8'h81, 8'h80, 0, "wrap_hold7");
    add(0, 8'h01, 8'h00, 0, "wrap_turn");
    add(0, 8'h81, 8'h01, 0, "wrap_g0");
    add(0, 8'h80, 8'h00, 0, "wrap_turn2");
    add(0, 8'h80, 8'h80, 0, "wrap_g7b");
    add(0, 8'h00, 8'h00, 0, "wrap_end");
    add(0, 8'h00, 8'h00, 0, "wrap_idle");
    for (int i = 0; i < 4; i++) add(1, 8'h28, 8'h08, 0, "wd_hold3");
    add(1, 8'h28, 8'h00, 1, "wd_revoke");
    add(1, 8'h28, 8'h20, 0, "wd_next5");
    add(1, 8'h28, 8'h20, 0, "wd_hold5");
    add(1, 8'h00, 8'h00, 0, "wd_turn");
    add(1, 8'h00, 8'h00, 0, "wd_idle");

    // Reset held with random requests: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_m = 8'($urandom_range(0, 255));
      req_w = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check_out(0, "rst_m", 8'h00, 1'b0);
      check_out(1, "rst_w", 8'h00, 1'b0);
      cmp("rst_state_m", 32'(st_m), 32'd0);
      cmp("rst_state_w", 32'(st_w), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_m = '0;
    req_w = '0;

    foreach (vecs[i]) begin
      @(negedge clk);
      req_m = vecs[i].sel ? 8'h00 : vecs[i].req;
      req_w = vecs[i].sel ? vecs[i].req : 8'h00;
      exp_q.push_back({vecs[i].sel, vecs[i].tout, vecs[i].gnt});
      name_q.push_back(vecs[i].name);
      @(posedge clk);
      #1;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check_out(e[9], nm, e[7:0], e[8]);
    end

    // Asynchronous reset mid-grant, with rr_ptr parked away from 0.
    @(negedge clk);
    req_m = 8'h02;
    req_w = 8'h00;
    @(posedge clk);
    #1;
    check_out(0, "ar_grant1", 8'h02, 1'b0);
    @(negedge clk);
    req_m = 8'hFF;
    @(posedge clk);
    #1;
    check_out(0, "ar_hold1", 8'h02, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out(0, "ar_async_clear", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out(0, "ar_restart0", 8'h01, 1'b0);
    @(negedge clk);
    req_m = 8'h00;
    @(posedge clk);
    #1;
    check_out(0, "ar_release", 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
